// File: rtl/decoder_scan_if.sv
// Control/status bundle between a scan controller and decoder_scan_sequencer.
// master drives start/stop/mode/mask; slave (the sequencer) drives sel and status.
interface decoder_scan_if;
   logic       start;
   logic       stop;
   logic       continuous;
   logic [7:0] mask;
   logic [2:0] sel;
   logic       sel_valid;
   logic       busy;
   logic       done;
   logic       wrap;

   modport master (
      output start, stop, continuous, mask,
      input  sel, sel_valid, busy, done, wrap
   );

   modport slave (
      input  start, stop, continuous, mask,
      output sel, sel_valid, busy, done, wrap
   );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Walks a 3-bit decoder select through the enabled channels in ascending order,
// holding each for DWELL clocks; single-sweep or continuous, with start/stop control.
module decoder_scan_sequencer #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   decoder_scan_if.slave        bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic             sel_valid_q, sel_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       mask_q, mask_d;
   logic [3:0]       next_s;

   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

   // {found, index} of the lowest set bit strictly above cur
   function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] cur);
      logic [3:0] res;
      res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) begin
            res = {1'b1, 3'(i)};
         end
      end
      return res;
   endfunction

   assign next_s = next_set(mask_q, sel_q);

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      wrap_d      = 1'b0;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               if (bus.mask != 8'd0) begin
                  mask_d      = bus.mask;
                  sel_d       = lowest_set(bus.mask);
                  sel_valid_d = 1'b1;
                  busy_d      = 1'b1;
                  cnt_d       = RELOAD;
                  state_d     = ST_SCAN;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            // stop takes priority over any channel advance or sweep end
            if (bus.stop) begin
               state_d     = ST_IDLE;
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
            end else if (cnt_q != {CNT_W{1'b0}}) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (next_s[3]) begin
               sel_d = next_s[2:0];
               cnt_d = RELOAD;
            end else if (bus.continuous && (bus.mask != 8'd0)) begin
               mask_d = bus.mask;
               sel_d  = lowest_set(bus.mask);
               wrap_d = 1'b1;
               cnt_d  = RELOAD;
            end else begin
               if (bus.continuous) begin
                  mask_d = bus.mask;
               end else begin
                  mask_d = mask_q;
               end
               state_d     = ST_IDLE;
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= 3'd0;
         sel_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         mask_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.sel_valid = sel_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: three instances with DWELL 4, 2 and 1.
// Observed vector layout is {sel[2:0], sel_valid, busy, done, wrap}.
module tb_decoder_scan_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   decoder_scan_if bus4 ();
   decoder_scan_if bus2 ();
   decoder_scan_if bus1 ();

   decoder_scan_sequencer #(.DWELL(4), .CNT_W(8)) u_d4 (.clk(clk), .rst(rst), .bus(bus4));
   decoder_scan_sequencer #(.DWELL(2), .CNT_W(8)) u_d2 (.clk(clk), .rst(rst), .bus(bus2));
   decoder_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_d1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      logic [6:0] g4, g2, g1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      g4 = {bus4.sel, bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
      g2 = {bus2.sel, bus2.sel_valid, bus2.busy, bus2.done, bus2.wrap};
      g1 = {bus1.sel, bus1.sel_valid, bus1.busy, bus1.done, bus1.wrap};
      checks++;
      if (g4 !== 7'd0) begin errors++; $display("FAIL reset_d4 got=%b exp=%b", g4, 7'd0); end
      checks++;
      if (g2 !== 7'd0) begin errors++; $display("FAIL reset_d2 got=%b exp=%b", g2, 7'd0); end
      checks++;
      if (g1 !== 7'd0) begin errors++; $display("FAIL reset_d1 got=%b exp=%b", g1, 7'd0); end
      rst = 1'b0;
   endtask

   task automatic test_full_sweep();
      logic [6:0] g, e;
      logic [2:0] es;
      logic [7:0] oh;
      @(posedge clk); #1;
      bus4.mask = 8'hFF; bus4.continuous = 1'b0; bus4.start = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         @(posedge clk); #1;
         bus4.start = 1'b0;
         es = (k <= 32) ? 3'((k - 1) / 4) : 3'd7;
         if (k <= 32)      e = {es, 1'b1, 1'b1, 1'b0, 1'b0};
         else if (k == 33) e = {3'd7, 1'b0, 1'b0, 1'b1, 1'b0};
         else              e = {3'd7, 4'b0000};
         g = {bus4.sel, bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL full_sweep k=%0d got=%b exp=%b", k, g, e); end
         if (k <= 32) begin
            oh = 8'd1 << bus4.sel;
            checks++;
            if (oh !== (8'd1 << es)) begin
               errors++; $display("FAIL onehot k=%0d got=%b exp=%b", k, oh, 8'd1 << es);
            end
         end
      end
   endtask

   task automatic test_sparse_mask();
      logic [6:0] g, e;
      logic [2:0] es;
      @(posedge clk); #1;
      bus4.mask = 8'b1010_0100; bus4.start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         bus4.start = 1'b0;
         if (k <= 4)      es = 3'd2;
         else if (k <= 8) es = 3'd5;
         else             es = 3'd7;
         if (k <= 12)      e = {es, 1'b1, 1'b1, 1'b0, 1'b0};
         else if (k == 13) e = {3'd7, 1'b0, 1'b0, 1'b1, 1'b0};
         else              e = {3'd7, 4'b0000};
         g = {bus4.sel, bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL sparse k=%0d got=%b exp=%b", k, g, e); end
      end
   endtask

   task automatic test_empty_mask();
      logic [3:0] g, e;
      @(posedge clk); #1;
      bus4.mask = 8'h00; bus4.start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         bus4.start = 1'b0;
         e = (k == 1) ? 4'b0010 : 4'b0000;
         g = {bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL empty_mask k=%0d got=%b exp=%b", k, g, e); end
      end
   endtask

   task automatic test_dwell1();
      logic [6:0] g, e;
      @(posedge clk); #1;
      bus1.mask = 8'hFF; bus1.continuous = 1'b0; bus1.start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         bus1.start = 1'b0;
         if (k <= 8)      e = {3'(k - 1), 1'b1, 1'b1, 1'b0, 1'b0};
         else if (k == 9) e = {3'd7, 1'b0, 1'b0, 1'b1, 1'b0};
         else             e = {3'd7, 4'b0000};
         g = {bus1.sel, bus1.sel_valid, bus1.busy, bus1.done, bus1.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL dwell1 k=%0d got=%b exp=%b", k, g, e); end
      end
   endtask

   task automatic test_continuous();
      logic [6:0] g, e;
      logic [2:0] es;
      logic       ew;
      @(posedge clk); #1;
      bus2.mask = 8'h81; bus2.continuous = 1'b1; bus2.start = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); #1;
         bus2.start = 1'b0;
         case (k)
            1, 2, 5, 6:  es = 3'd0;
            3, 4, 7, 8:  es = 3'd7;
            default:     es = 3'd1;
         endcase
         ew = (k == 5) || (k == 9) || (k == 11) || (k == 13);
         if (k <= 13) e = {es, 1'b1, 1'b1, 1'b0, ew};
         else         e = {3'd1, 4'b0000};
         g = {bus2.sel, bus2.sel_valid, bus2.busy, bus2.done, bus2.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL continuous k=%0d got=%b exp=%b", k, g, e); end
         if (k == 6)  bus2.mask = 8'h02;
         if (k == 13) bus2.stop = 1'b1;
      end
      bus2.stop = 1'b0; bus2.continuous = 1'b0;
   endtask

   task automatic test_stop_at_end();
      logic [6:0] g, e;
      @(posedge clk); #1;
      bus4.mask = 8'h01; bus4.start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         bus4.start = 1'b0;
         e = (k <= 4) ? {3'd0, 1'b1, 1'b1, 1'b0, 1'b0} : {3'd0, 4'b0000};
         g = {bus4.sel, bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL stop_at_end k=%0d got=%b exp=%b", k, g, e); end
         if (k == 4) bus4.stop = 1'b1;
         if (k == 5) bus4.stop = 1'b0;
      end
   endtask

   task automatic test_reset_midscan();
      logic [6:0] g, e;
      @(posedge clk); #1;
      bus4.mask = 8'hFF; bus4.start = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         bus4.start = 1'b0;
         if (k <= 14) e = {3'((k - 1) / 4), 1'b1, 1'b1, 1'b0, 1'b0};
         else         e = 7'd0;
         g = {bus4.sel, bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL reset_midscan k=%0d got=%b exp=%b", k, g, e); end
         if (k == 14) rst = 1'b1;
         if (k == 15) rst = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] g, e;
      @(posedge clk); #1;
      bus4.mask = 8'b0001_0010; bus4.start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         bus4.start = (k == 2) || (k == 6);
         if (k == 3) bus4.mask = 8'hFF;
         if (k <= 4)       e = {3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
         else if (k <= 8)  e = {3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
         else if (k == 9)  e = {3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
         else              e = {3'd4, 4'b0000};
         g = {bus4.sel, bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== e) begin errors++; $display("FAIL back_to_back k=%0d got=%b exp=%b", k, g, e); end
      end
   endtask

   task automatic test_start_stop_idle();
      logic [3:0] g;
      @(posedge clk); #1;
      bus4.mask = 8'hFF; bus4.start = 1'b1; bus4.stop = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         bus4.start = 1'b0; bus4.stop = 1'b0;
         g = {bus4.sel_valid, bus4.busy, bus4.done, bus4.wrap};
         checks++;
         if (g !== 4'b0000) begin
            errors++; $display("FAIL start_stop_idle k=%0d got=%b exp=%b", k, g, 4'b0000);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus4.start = 1'b0; bus4.stop = 1'b0; bus4.continuous = 1'b0; bus4.mask = 8'h00;
      bus2.start = 1'b0; bus2.stop = 1'b0; bus2.continuous = 1'b0; bus2.mask = 8'h00;
      bus1.start = 1'b0; bus1.stop = 1'b0; bus1.continuous = 1'b0; bus1.mask = 8'h00;
      test_reset();
      test_full_sweep();
      test_sparse_mask();
      test_empty_mask();
      test_dwell1();
      test_continuous();
      test_stop_at_end();
      test_reset_midscan();
      test_back_to_back();
      test_start_stop_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
